rp_asg_axi_arb: RTL

RP_ASG_AXI_ARB -- requirements
Module: rp_asg_axi_arb

---
 rtl/rp_asg_axi_arb.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/rp_asg_axi_arb.sv
// Two-channel round-robin arbiter in front of a single AXI read burst engine.
// Define RP_ASG_ARB_STAT_EN to build the grant/wait statistics counters.
`timescale 1ns/1ps
module rp_asg_axi_arb #(
   parameter int unsigned DW = 64,
   parameter int unsigned AW = 32
) (
   input  logic            axi_clk_i,
   input  logic            axi_rstn_i,
   input  logic [1:0]      req_val_i,
   output logic [1:0]      req_rdy_o,
   input  logic [2*AW-1:0] req_addr_i,
   input  logic [7:0]      req_size_i,
   input  logic [5:0]      req_rsize_i,
   input  logic [1:0]      ch_clr_i,
   output logic [AW-1:0]   ctrl_addr_o,
   output logic [3:0]      ctrl_size_o,
   output logic [2:0]      ctrl_rsize_o,
   output logic            ctrl_val_o,
   input  logic            ctrl_busy_i,
   input  logic [DW-1:0]   rd_data_i,
   input  logic [AW-1:0]   rd_addr_i,
   input  logic            rd_dval_i,
   output logic            rd_drdy_o,
   output logic [2*DW-1:0] dat_data_o,
   output logic [2*AW-1:0] dat_addr_o,
   output logic [1:0]      dat_wr_o,
   input  logic [1:0]      dat_rdy_i,
   output logic [1:0]      grant_o,
   output logic [95:0]     stat_o
);

   localparam int unsigned SW = 4;
   localparam int unsigned RW = 3;
   localparam int unsigned CW = 5;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_XFER  = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          owner_q, owner_d;
   logic          last_q, last_d;
   logic          disc_q, disc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] addr_d;
   logic [SW-1:0] size_d;
   logic [RW-1:0] rsize_d;
   logic          ctrl_val_d;
   logic [1:0]    req_rdy_d;
   logic [1:0]    grant_d;

   logic [1:0]    elig_c;
   logic          pick_c;
   logic          grant_ev_c;
   logic          disc_c;
   logic          acc_c;

   // Cleared channels never compete; ties go to the channel not granted last.
   assign elig_c     = req_val_i & ~ch_clr_i;
   assign pick_c     = (elig_c == 2'b11) ? ~last_q : elig_c[1];
   assign grant_ev_c = (state_q == ST_IDLE) && (elig_c != 2'b00) && !ctrl_busy_i;

   // A flush of the owner takes effect on the very beat it coincides with.
   assign disc_c = disc_q ||
                   (ch_clr_i[owner_q] && ((state_q == ST_ISSUE) || (state_q == ST_XFER)));

   assign rd_drdy_o  = (state_q == ST_XFER) && (disc_c || dat_rdy_i[owner_q]);
   assign acc_c      = rd_dval_i && rd_drdy_o;
   assign dat_wr_o   = (acc_c && !disc_c) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
   assign dat_data_o = {rd_data_i, rd_data_i};
   assign dat_addr_o = {rd_addr_i, rd_addr_i};

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      last_d     = last_q;
      disc_d     = disc_q;
      cnt_d      = cnt_q;
      addr_d     = ctrl_addr_o;
      size_d     = ctrl_size_o;
      rsize_d    = ctrl_rsize_o;
      ctrl_val_d = 1'b0;
      req_rdy_d  = 2'b00;
      grant_d    = grant_o;
      case (state_q)
         ST_IDLE: begin
            if (grant_ev_c) begin
               owner_d    = pick_c;
               last_d     = pick_c;
               disc_d     = 1'b0;
               req_rdy_d  = pick_c ? 2'b10 : 2'b01;
               grant_d    = pick_c ? 2'b10 : 2'b01;
               ctrl_val_d = 1'b1;
               addr_d     = pick_c ? req_addr_i[AW +: AW] : req_addr_i[0 +: AW];
               size_d     = pick_c ? req_size_i[SW +: SW] : req_size_i[0 +: SW];
               rsize_d    = pick_c ? req_rsize_i[RW +: RW] : req_rsize_i[0 +: RW];
               state_d    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            cnt_d   = CW'(ctrl_size_o) + CW'(1);
            disc_d  = disc_c;
            state_d = ST_XFER;
         end
         ST_XFER: begin
            disc_d = disc_c;
            if (acc_c) begin
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = ST_DRAIN;
               end
            end
         end
         ST_DRAIN: begin
            if (!ctrl_busy_i) begin
               grant_d = 2'b00;
               state_d = ST_IDLE;
            end
         end
         default: begin
            grant_d = 2'b00;
            state_d = ST_IDLE;
         end
      endcase
   end

   // Reset leaves the pointer on ch1 so the first grant goes to ch0.
   always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
      if (!axi_rstn_i) begin
         state_q      <= ST_IDLE;
         owner_q      <= 1'b0;
         last_q       <= 1'b1;
         disc_q       <= 1'b0;
         cnt_q        <= '0;
         ctrl_addr_o  <= '0;
         ctrl_size_o  <= '0;
         ctrl_rsize_o <= '0;
         ctrl_val_o   <= 1'b0;
         req_rdy_o    <= 2'b00;
         grant_o      <= 2'b00;
      end else begin
         state_q      <= state_d;
         owner_q      <= owner_d;
         last_q       <= last_d;
         disc_q       <= disc_d;
         cnt_q        <= cnt_d;
         ctrl_addr_o  <= addr_d;
         ctrl_size_o  <= size_d;
         ctrl_rsize_o <= rsize_d;
         ctrl_val_o   <= ctrl_val_d;
         req_rdy_o    <= req_rdy_d;
         grant_o      <= grant_d;
      end
   end

`ifdef RP_ASG_ARB_STAT_EN
   logic [31:0] g0_q, g1_q, wait_q, max_q;
   logic [31:0] wait_inc_c;
   logic        pend_c;

   // A waiting cycle is an IDLE cycle with an eligible request held off by the engine.
   assign pend_c     = (state_q == ST_IDLE) && (elig_c != 2'b00) && ctrl_busy_i;
   assign wait_inc_c = (wait_q == 32'hFFFF_FFFF) ? wait_q : wait_q + 32'd1;

   always_ff @(posedge axi_clk_i or negedge axi_rstn_i) begin
      if (!axi_rstn_i) begin
         g0_q   <= '0;
         g1_q   <= '0;
         wait_q <= '0;
         max_q  <= '0;
      end else begin
         if (grant_ev_c && !pick_c) g0_q <= g0_q + 32'd1;
         if (grant_ev_c &&  pick_c) g1_q <= g1_q + 32'd1;
         if (pend_c) begin
            wait_q <= wait_inc_c;
            if (wait_inc_c > max_q) max_q <= wait_inc_c;
         end else begin
            wait_q <= '0;
         end
      end
   end

   assign stat_o = {max_q, g1_q, g0_q};
`else
   assign stat_o = '0;
`endif

endmodule
